dff_mode_reg: RTL and testbench
===============================

# dff_mode_reg

Parametrised multi-mode register with a held-value override and change detection: the generalised successor to the single-bit D flip-flop. It stores WIDTH bits and, per clock, holds, loads in parallel, shifts left or shifts right. A force/release override replaces the output with a supplied value while asserted and leaves that value in the register on release. It serves as the common storage/shift element for datapath and test-control logic.

## Interface
- WIDTH, 8, register width in bits (≥2)
- RST_VAL, {WIDTH{1'b0}}, register value after reset

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  operation enable; when low the register holds (mode ignored)
- mode  in  2  operation: 00 hold, 01 load, 10 shift left, 11 shift right
- din  in  WIDTH  parallel load data
- sin  in  1  serial input bit for shifts
- frc  in  1  force override, level-sensitive
- frc_val  in  WIDTH  value driven while forced
- q  out  WIDTH  register output, with override applied
- sout  out  1  serial output: q[WIDTH-1] in shift-left mode, q[0] otherwise
- chg  out  1  registered pulse, high for one cycle after the stored value changes

## Operation
- Internal register r; priority at each rising edge: rst > frc > en/mode.
- rst=1: r ← RST_VAL, chg ← 0. Applies regardless of frc, en or mode.
- frc=1 (rst=0): r ← frc_val every edge; en, mode and din are ignored.
- en=1, frc=0: mode 00 r unchanged; 01 r ← din; 10 r ← {r[WIDTH-2:0], sin}; 11 r ← {sin, r[WIDTH-1:1]}.
- en=0, frc=0: r unchanged.
- q = frc ? frc_val : r, combinational. The override is visible in the same cycle frc rises.
- Release (frc 1→0): r already holds the last sampled frc_val. q shows r with no glitch to the pre-force value. Normal operation resumes at the next edge.
- sout is derived from q, so it reflects the forced value while frc=1.
- chg ← (r_next != r) at each edge with rst=0. A load of an identical value, or a shift that leaves r unchanged (e.g. all-ones shifted with sin=1), gives chg=0.

## Timing
- Reset values: r = RST_VAL, q = RST_VAL (if frc=0), chg = 0, sout per RST_VAL bit.
- Load/shift latency: 1 cycle. r and q update on the edge that samples en=1.
- chg is asserted in the cycle following the updating edge and lasts exactly one cycle per change. Back-to-back changes keep chg high continuously.
- Force: q changes combinationally in the same cycle. r captures frc_val at each edge while frc=1.
- frc toggling between edges: only the value present at the edge enters r.
- Reset mid-force: r ← RST_VAL while q still shows frc_val. On release, q = RST_VAL unless a forced edge occurred after rst fell.
- Simultaneous frc rise and en=1 load: the force wins and din is discarded.
- Shifts have no wrap-around; the bit shifted out is lost after the edge (sout shows it before the edge).

## Structure
- Shared package dff_pkg: 2-bit mode typedef and constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR; these are reused by the test-control sequencer.
- One always block for r/chg next-state logic, plus continuous assignments for q and sout.
- No sub-module; a per-bit cell gains nothing because the shift modes need neighbouring bits.

## Test plan
Values below use WIDTH=8, RST_VAL=8'hA5.
- Reset with en=1, mode=01, din=8'hFF, rst=1 for 2 edges -> r=q=8'hA5, chg=0 throughout and one cycle after release.
- Load 8'h3C, then mode=10 with sin=1 for 2 edges -> q=8'h3C, 8'h79, 8'hF3; sout=0,0,1; chg high 3 consecutive cycles.
- Shift right with sin=0 from 8'h01 for 2 edges -> q=8'h00 and sout=1 before the first edge; chg=1 then 0.
- Load the same 8'h5A twice -> chg pulses once only; en=0 with mode=01 and din=8'h00 -> q stays 8'h5A, chg=0.
- Force frc_val=8'hC3 mid-cycle -> q=8'hC3 immediately. Drive en=1, load 8'h11 during force -> ignored. Release -> q stays 8'hC3. Next load of 8'h11 -> q=8'h11.
- rst=1 for one edge during force 8'hC3 -> q=8'hC3 while forced. Release in the same cycle rst falls -> q=8'hA5.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared mode encoding for the multi-mode register and the test-control
// sequencer that drives it.
package dff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } mode_t;

endpackage

// File: rtl/dff_mode_reg_if.sv
// Control/data bundle for dff_mode_reg. The master drives the operation
// and override inputs; the slave (the register) returns q, sout and chg.
// There is no valid/ready handshake: every input is sampled on every
// rising edge, and en qualifies the operation instead.
interface dff_mode_reg_if #(
  parameter int WIDTH = 8
);
  import dff_pkg::*;

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic             frc;
  logic [WIDTH-1:0] frc_val;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             chg;

  modport master (
    output en, mode, din, sin, frc, frc_val,
    input  q, sout, chg
  );

  modport slave (
    input  en, mode, din, sin, frc, frc_val,
    output q, sout, chg
  );

endinterface

// File: rtl/dff_mode_reg.sv
// WIDTH-bit hold/load/shift register with a level-sensitive force override
// and a one-cycle change pulse. Edge priority: rst > frc > en/mode.
module dff_mode_reg
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                 clk,
  input logic                 rst,
  dff_mode_reg_if.slave       bus
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_next;
  logic             chg_r;

  // Next stored value: force wins over the enabled operation; the forced
  // value is captured so that release shows it without a glitch.
  always_comb begin
    r_next = r;
    if (bus.frc) begin
      r_next = bus.frc_val;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_LOAD: r_next = bus.din;
        MODE_SHL:  r_next = {r[WIDTH-2:0], bus.sin};
        MODE_SHR:  r_next = {bus.sin, r[WIDTH-1:1]};
        default:   r_next = r;
      endcase
    end
  end

  // Storage and change flag; chg compares against the old value so a
  // reload of identical data or a no-op shift produces no pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= RST_VAL;
      chg_r <= 1'b0;
    end else begin
      r     <= r_next;
      chg_r <= (r_next != r);
    end
  end

  // Override is combinational so it is visible in the cycle frc rises;
  // sout follows q so it reflects a forced value too.
  assign bus.q    = bus.frc ? bus.frc_val : r;
  assign bus.sout = (bus.mode == MODE_SHL) ? bus.q[WIDTH-1] : bus.q[0];
  assign bus.chg  = chg_r;

endmodule

// File: tb/tb_dff_mode_reg.sv
// Directed table-driven bench for dff_mode_reg (WIDTH=8, RST_VAL=8'hA5).
// Each vector is driven at a falling edge, takes one rising edge, and the
// outputs are compared at the next falling edge with the inputs still held.
module tb_dff_mode_reg;
  import dff_pkg::*;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] RST_VAL = 8'hA5;

  typedef struct {
    logic             rst;
    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic             frc;
    logic [WIDTH-1:0] frc_val;
    logic [WIDTH-1:0] exp_q;
    logic             exp_sout;
    logic             exp_chg;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  vec_t vecs[$];

  dff_mode_reg_if #(.WIDTH(WIDTH)) bus ();

  dff_mode_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic add(input logic r, input logic e, input mode_t m,
                     input logic [WIDTH-1:0] d, input logic s,
                     input logic f, input logic [WIDTH-1:0] fv,
                     input logic [WIDTH-1:0] eq, input logic es,
                     input logic ec);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.din = d; v.sin = s;
    v.frc = f; v.frc_val = fv;
    v.exp_q = eq; v.exp_sout = es; v.exp_chg = ec;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst         = v.rst;
    bus.en      = v.en;
    bus.mode    = v.mode;
    bus.din     = v.din;
    bus.sin     = v.sin;
    bus.frc     = v.frc;
    bus.frc_val = v.frc_val;
  endtask

  // Scoreboard comparison
  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.en = 1'b0; bus.mode = MODE_HOLD; bus.din = '0; bus.sin = 1'b0;
    bus.frc = 1'b0; bus.frc_val = '0;

    //   rst en mode       din    sin frc fv     q      sout chg
    // Reset dominates an enabled load, for two edges, then one idle cycle.
    add(1, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00, 8'hA5, 1, 0);
    add(1, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00, 8'hA5, 1, 0);
    add(0, 0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 8'hA5, 1, 0);
    // Load then two left shifts with sin=1: chg high three cycles.
    add(0, 1, MODE_LOAD, 8'h3C, 0, 0, 8'h00, 8'h3C, 0, 1);
    add(0, 1, MODE_SHL,  8'h00, 1, 0, 8'h00, 8'h79, 0, 1);
    add(0, 1, MODE_SHL,  8'h00, 1, 0, 8'h00, 8'hF3, 1, 1);
    add(0, 0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 8'hF3, 1, 0);
    // Right shift of 8'h01 with sin=0 loses the bit; second shift no change.
    add(0, 1, MODE_LOAD, 8'h01, 0, 0, 8'h00, 8'h01, 1, 1);
    add(0, 1, MODE_SHR,  8'h00, 0, 0, 8'h00, 8'h00, 0, 1);
    add(0, 1, MODE_SHR,  8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    // Identical reload pulses once; en=0 ignores mode/din.
    add(0, 1, MODE_LOAD, 8'h5A, 0, 0, 8'h00, 8'h5A, 0, 1);
    add(0, 1, MODE_LOAD, 8'h5A, 0, 0, 8'h00, 8'h5A, 0, 0);
    add(0, 0, MODE_LOAD, 8'h00, 0, 0, 8'h00, 8'h5A, 0, 0);
    // All-ones shifted with sin=1 in both directions gives no change.
    add(0, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00, 8'hFF, 1, 1);
    add(0, 1, MODE_SHL,  8'h00, 1, 0, 8'h00, 8'hFF, 1, 0);
    add(0, 1, MODE_SHR,  8'h00, 1, 0, 8'h00, 8'hFF, 1, 0);
    add(0, 1, MODE_SHR,  8'h00, 0, 0, 8'h00, 8'h7F, 1, 1);
    // Force with a simultaneous load: force wins, value persists on release.
    add(0, 1, MODE_LOAD, 8'h11, 0, 1, 8'hC3, 8'hC3, 1, 1);
    add(0, 0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 8'hC3, 1, 0);
    add(0, 1, MODE_LOAD, 8'h11, 0, 0, 8'h00, 8'h11, 1, 1);
    // Reset under force: q stays forced, release shows RST_VAL.
    add(0, 0, MODE_HOLD, 8'h00, 0, 1, 8'hC3, 8'hC3, 1, 1);
    add(1, 0, MODE_HOLD, 8'h00, 0, 1, 8'hC3, 8'hC3, 1, 0);
    add(0, 0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 8'hA5, 1, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_q", i),    bus.q,              vecs[i].exp_q);
      check($sformatf("vec%0d_sout", i), {7'b0, bus.sout},   {7'b0, vecs[i].exp_sout});
      check($sformatf("vec%0d_chg", i),  {7'b0, bus.chg},    {7'b0, vecs[i].exp_chg});
    end

    // Mid-cycle force is visible at once; a pulse that drops before the
    // edge never reaches the register.
    bus.en = 1'b0; bus.mode = MODE_HOLD;
    bus.frc_val = 8'hC3; bus.frc = 1'b1;
    #1;
    check("midforce_q", bus.q, 8'hC3);
    check("midforce_sout", {7'b0, bus.sout}, 8'h01);
    bus.frc = 1'b0;
    #1;
    check("glitch_release_q", bus.q, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    check("glitch_edge_q", bus.q, 8'hA5);
    check("glitch_edge_chg", {7'b0, bus.chg}, 8'h00);

    // sout shows the bit about to be lost before a right-shift edge.
    bus.en = 1'b1; bus.mode = MODE_LOAD; bus.din = 8'h01;
    @(posedge clk);
    @(negedge clk);
    bus.mode = MODE_SHR; bus.sin = 1'b0;
    #1;
    check("pre_shr_sout", {7'b0, bus.sout}, 8'h01);
    bus.mode = MODE_SHL;
    #1;
    check("pre_shl_sout", {7'b0, bus.sout}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("shl_q", bus.q, 8'h02);
    check("shl_chg", {7'b0, bus.chg}, 8'h01);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
